// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU function codes,
// forward-select encoding and the control bundle carried through ID/EX.
package ex_operand_stage_pkg;

   // ALU function codes
   localparam logic [5:0] FUN_ADD  = 6'h00;
   localparam logic [5:0] FUN_SUB  = 6'h01;
   localparam logic [5:0] FUN_AND  = 6'h18;
   localparam logic [5:0] FUN_SLL  = 6'h20;
   localparam logic [5:0] FUN_SRL  = 6'h21;
   localparam logic [5:0] FUN_SRA  = 6'h22;
   localparam logic [5:0] FUN_ROR  = 6'h23;
   localparam logic [5:0] FUN_SLT  = 6'h30;
   localparam logic [5:0] FUN_SLTU = 6'h31;

   // Operand source chosen by the forwarding network
   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   // Control portion of the ID/EX register
   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       sign;
      logic       srca_shamt;
      logic       srcb_imm;
      logic [5:0] fun;
   } ex_ctrl_t;

   // A bubble is an invalid slot that writes nothing and has fun 0
   localparam ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/ex_operand_stage_forward_mux.sv
// Per-operand forwarding: picks EX/MEM, then MEM/WB, then the latched
// register-file value. Register 0 is hard-wired and never forwarded.
module ex_forward_mux
   import ex_operand_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] idx,
   input  logic [DW-1:0] rf_data,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] exmem_dst,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_reg_write,
   input  logic [RW-1:0] memwb_dst,
   input  logic [DW-1:0] memwb_result,
   output logic [DW-1:0] data
);

   fwd_sel_e sel;

   // Select the youngest in-flight producer of idx; EX/MEM outranks MEM/WB
   always_comb begin
      sel = FWD_RF;
      if (exmem_reg_write && (exmem_dst == idx) && (idx != '0))
         sel = FWD_EXMEM;
      else if (memwb_reg_write && (memwb_dst == idx) && (idx != '0))
         sel = FWD_MEMWB;
   end

   // 3:1 operand mux
   always_comb begin
      case (sel)
         FWD_EXMEM: data = exmem_result;
         FWD_MEMWB: data = memwb_result;
         default:   data = rf_data;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding. Handles
// load-use bubbles, branch flush and downstream hold, and feeds the ALU
// and the store-data path into MEM.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_shamt,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_dst,
   input  logic [5:0]    id_fun,
   input  logic          id_sign,
   input  logic          id_srca_shamt,
   input  logic          id_srcb_imm,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          flush,
   input  logic          ex_hold,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] exmem_dst,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_reg_write,
   input  logic [RW-1:0] memwb_dst,
   input  logic [DW-1:0] memwb_result,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [5:0]    alu_fun,
   output logic          alu_sign,
   output logic [DW-1:0] ex_store_data,
   output logic          ex_valid,
   output logic [RW-1:0] ex_dst,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          stall_id
);

   ex_ctrl_t      id_ctrl;
   ex_ctrl_t      ctrl_p1;
   logic [DW-1:0] rs_data_p1, rt_data_p1, imm_p1;
   logic [4:0]    shamt_p1;
   logic [RW-1:0] rs_p1, rt_p1, dst_p1;
   logic          load_use;
   logic [DW-1:0] fwd_rs, fwd_rt;

   assign id_ctrl = '{valid:      id_valid,
                      reg_write:  id_reg_write,
                      mem_read:   id_mem_read,
                      mem_write:  id_mem_write,
                      sign:       id_sign,
                      srca_shamt: id_srca_shamt,
                      srcb_imm:   id_srcb_imm,
                      fun:        id_fun};

   // A load in EX cannot forward its data yet, so a dependent ID instruction waits
   assign load_use = ctrl_p1.valid & ctrl_p1.mem_read & (dst_p1 != '0) &
                     ((dst_p1 == id_rs) | (dst_p1 == id_rt)) & id_valid;
   assign stall_id = load_use | ex_hold;

   // ID/EX register: flush beats hold, hold beats load-use bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_p1    <= BUBBLE;
         rs_data_p1 <= '0;
         rt_data_p1 <= '0;
         imm_p1     <= '0;
         shamt_p1   <= '0;
         rs_p1      <= '0;
         rt_p1      <= '0;
         dst_p1     <= '0;
      end else if (flush || (!ex_hold && load_use)) begin
         ctrl_p1    <= BUBBLE;
         rs_data_p1 <= '0;
         rt_data_p1 <= '0;
         imm_p1     <= '0;
         shamt_p1   <= '0;
         rs_p1      <= '0;
         rt_p1      <= '0;
         dst_p1     <= '0;
      end else if (!ex_hold) begin
         ctrl_p1    <= id_ctrl;
         rs_data_p1 <= id_rs_data;
         rt_data_p1 <= id_rt_data;
         imm_p1     <= id_imm;
         shamt_p1   <= id_shamt;
         rs_p1      <= id_rs;
         rt_p1      <= id_rt;
         dst_p1     <= id_dst;
      end
   end

   // ---- EX stage: forwarding stays live even while the register is held ----
   ex_forward_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .idx             (rs_p1),
      .rf_data         (rs_data_p1),
      .exmem_reg_write (exmem_reg_write),
      .exmem_dst       (exmem_dst),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dst       (memwb_dst),
      .memwb_result    (memwb_result),
      .data            (fwd_rs)
   );

   ex_forward_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .idx             (rt_p1),
      .rf_data         (rt_data_p1),
      .exmem_reg_write (exmem_reg_write),
      .exmem_dst       (exmem_dst),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_dst       (memwb_dst),
      .memwb_result    (memwb_result),
      .data            (fwd_rt)
   );

   assign alu_a         = ctrl_p1.srca_shamt ? {{(DW-5){1'b0}}, shamt_p1} : fwd_rs;
   assign alu_b         = ctrl_p1.srcb_imm ? imm_p1 : fwd_rt;
   assign ex_store_data = fwd_rt;

   assign alu_fun      = ctrl_p1.fun;
   assign alu_sign     = ctrl_p1.sign;
   assign ex_valid     = ctrl_p1.valid;
   assign ex_dst       = dst_p1;
   assign ex_reg_write = ctrl_p1.reg_write;
   assign ex_mem_read  = ctrl_p1.mem_read;
   assign ex_mem_write = ctrl_p1.mem_write;

endmodule
